// File: rtl/norm_shift.sv
// Multicycle left-normalizer: shifts an operand by its leading-zero count one log-stage
// per cycle (16,8,4,2,1) and flags counts that do not match the operand.
module norm_shift #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [CNT_W-1:0] in_lz_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_norm_o,
    output logic             out_err_o
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [CNT_W-1:0]     lz_q, lz_d;
    logic [WIDTH-1:0]     val_q, val_d;
    logic                 lost_q, lost_d;
    logic [2:0]           step_q, step_d;
    logic [WIDTH-1:0]     norm_q, norm_d;
    logic                 err_q, err_d;

    logic                 sh_en;
    logic [4:0]           amt;
    logic [2*WIDTH-1:0]   ext;
    logic [WIDTH-1:0]     stage_val;
    logic                 stage_lost;

    // One shift stage per cycle; the upper half of ext catches bits pushed past the MSB.
    always_comb begin
        sh_en = 1'b0;
        amt   = 5'd0;
        case (step_q)
            3'd0:    begin sh_en = lz_q[4]; amt = 5'd16; end
            3'd1:    begin sh_en = lz_q[3]; amt = 5'd8;  end
            3'd2:    begin sh_en = lz_q[2]; amt = 5'd4;  end
            3'd3:    begin sh_en = lz_q[1]; amt = 5'd2;  end
            3'd4:    begin sh_en = lz_q[0]; amt = 5'd1;  end
            default: begin sh_en = 1'b0;    amt = 5'd0;  end
        endcase
        if (!sh_en || lz_q[5]) begin
            amt = 5'd0;
        end
        ext        = {{WIDTH{1'b0}}, val_q} << amt;
        stage_val  = ext[WIDTH-1:0];
        stage_lost = |ext[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        lz_d    = lz_q;
        val_d   = val_q;
        lost_d  = lost_q;
        step_d  = step_q;
        norm_d  = norm_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (in_valid_i) begin
                    a_d     = in_a_i;
                    lz_d    = in_lz_i;
                    val_d   = in_a_i;
                    lost_d  = 1'b0;
                    step_d  = 3'd0;
                    state_d = StShift;
                end
            end
            StShift: begin
                val_d  = stage_val;
                lost_d = lost_q | stage_lost;
                step_d = step_q + 3'd1;
                if (step_q == 3'd4) begin
                    state_d = StDone;
                    step_d  = 3'd0;
                    if (lz_q > CNT_W'(32)) begin
                        norm_d = '0;
                        err_d  = 1'b1;
                    end else if (a_q == '0) begin
                        norm_d = '0;
                        err_d  = (lz_q != CNT_W'(32));
                    end else if (lz_q == CNT_W'(32)) begin
                        norm_d = '0;
                        err_d  = 1'b1;
                    end else begin
                        norm_d = stage_val;
                        err_d  = lost_d | ~stage_val[WIDTH-1];
                    end
                end
            end
            StDone: begin
                if (out_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            a_q     <= '0;
            lz_q    <= '0;
            val_q   <= '0;
            lost_q  <= 1'b0;
            step_q  <= 3'd0;
            norm_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            lz_q    <= lz_d;
            val_q   <= val_d;
            lost_q  <= lost_d;
            step_q  <= step_d;
            norm_q  <= norm_d;
            err_q   <= err_d;
        end
    end

    assign in_ready_o  = (state_q == StIdle);
    assign out_valid_o = (state_q == StDone);
    assign out_norm_o  = norm_q;
    assign out_err_o   = err_q;

endmodule

// File: tb/tb_norm_shift.sv
// Randomized and directed bench for norm_shift, checked against an arithmetic reference model.
module tb_norm_shift;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [5:0]  in_lz;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_norm;
    logic        out_err;

    int checks = 0;
    int errors = 0;

    norm_shift dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_a_i      (in_a),
        .in_lz_i     (in_lz),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_norm_o  (out_norm),
        .out_err_o   (out_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Reference: whole-value arithmetic from the error rules.
    function automatic void model(input logic [31:0] a, input int l,
                                  output logic [31:0] norm, output logic err);
        logic [63:0] prod;
        if (l > 32) begin
            norm = 32'h0; err = 1'b1;
        end else if (a == 32'h0) begin
            norm = 32'h0; err = (l != 32);
        end else if (l == 32) begin
            norm = 32'h0; err = 1'b1;
        end else begin
            prod = {32'h0, a} << l;
            norm = prod[31:0];
            err  = (prod[63:32] != 32'h0) || !norm[31];
        end
    endfunction

    function automatic int clz(input logic [31:0] a);
        for (int i = 31; i >= 0; i--) begin
            if (a[i]) return 31 - i;
        end
        return 32;
    endfunction

    task automatic start_op(input logic [31:0] a, input logic [5:0] l);
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_lz    = l;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_norm !== 32'h0) begin errors++; $display("FAIL reset_out_norm got %h want 0", out_norm); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err got %b want 0", out_err); end
    endtask

    task automatic test_basic();
        int lat;
        @(negedge clk);
        out_ready = 1'b1;
        start_op(32'h00F0_0000, 6'd8);
        wait_valid(lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency got %0d want 5", lat); end
        checks++; if (out_norm !== 32'hF000_0000) begin errors++; $display("FAIL basic_norm got %h want f0000000", out_norm); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL basic_err got %b want 0", out_err); end
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_idle got %b want 1", in_ready); end
        out_ready = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] ta [8] = '{32'h0, 32'h0, 32'h1, 32'h8000_0000,
                                32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0001};
        int          tl [8] = '{32, 5, 31, 0, 17, 15, 40, 33};
        logic [31:0] tn [8] = '{32'h0, 32'h0, 32'h8000_0000, 32'h8000_0000,
                                32'hFFFE_0000, 32'h7FFF_8000, 32'h0, 32'h0};
        logic        te [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        int lat;
        for (int i = 0; i < 8; i++) begin
            start_op(ta[i], 6'(tl[i]));
            wait_valid(lat);
            checks++; if (lat !== 5) begin errors++; $display("FAIL dir%0d_latency got %0d want 5", i, lat); end
            checks++; if (out_norm !== tn[i]) begin errors++; $display("FAIL dir%0d_norm got %h want %h", i, out_norm, tn[i]); end
            checks++; if (out_err !== te[i]) begin errors++; $display("FAIL dir%0d_err got %b want %b", i, out_err, te[i]); end
            release_out();
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          l;
        logic [31:0] en;
        logic        ee;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            a = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) a = 32'h0;
            if ($urandom_range(0, 1) == 0) l = clz(a);
            else l = int'($urandom_range(0, 40));
            model(a, l, en, ee);
            start_op(a, 6'(l));
            wait_valid(lat);
            checks++; if (lat !== 5) begin errors++; $display("FAIL rnd%0d_latency got %0d want 5", i, lat); end
            checks++; if (out_norm !== en) begin errors++; $display("FAIL rnd%0d_norm a=%h l=%0d got %h want %h", i, a, l, out_norm, en); end
            checks++; if (out_err !== ee) begin errors++; $display("FAIL rnd%0d_err a=%h l=%0d got %b want %b", i, a, l, out_err, ee); end
            release_out();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        start_op(32'h0001_0000, 6'd15);
        wait_valid(lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL bp_latency got %0d want 5", lat); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp%0d_valid got %b want 1", c, out_valid); end
            checks++; if (out_norm !== 32'h8000_0000) begin errors++; $display("FAIL bp%0d_norm got %h want 80000000", c, out_norm); end
            checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL bp%0d_err got %b want 0", c, out_err); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp%0d_in_ready got %b want 0", c, in_ready); end
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 32'h0000_0003;
        in_lz     = 6'd30;
        @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_release_valid got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_release_ready got %b want 1", in_ready); end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept got %b want 0", in_ready); end
        wait_valid(lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_latency got %0d want 5", lat); end
        checks++; if (out_norm !== 32'hC000_0000) begin errors++; $display("FAIL b2b_norm got %h want c0000000", out_norm); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL b2b_err got %b want 0", out_err); end
        release_out();
    endtask

    task automatic test_reset_mid();
        int lat;
        start_op(32'h0000_FFFF, 6'd16);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmid_in_ready got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid got %b want 0", out_valid); end
        checks++; if (out_norm !== 32'h0) begin errors++; $display("FAIL rmid_out_norm got %h want 0", out_norm); end
        lat = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (out_valid === 1'b1) lat++;
        end
        checks++; if (lat !== 0) begin errors++; $display("FAIL rmid_dropped got %0d valid cycles want 0", lat); end
        start_op(32'h0100_0000, 6'd7);
        wait_valid(lat);
        checks++; if (lat !== 5) begin errors++; $display("FAIL rmid_next_latency got %0d want 5", lat); end
        checks++; if (out_norm !== 32'h8000_0000) begin errors++; $display("FAIL rmid_next_norm got %h want 80000000", out_norm); end
        checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL rmid_next_err got %b want 0", out_err); end
        release_out();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 32'h0;
        in_lz     = 6'd0;
        out_ready = 1'b0;
        test_reset();
        test_basic();
        test_directed();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
